// File: rtl/layers_arb_pkg.sv
// Shared types and constants for the frame-atomic layer arbiter.
package layers_arb_pkg;

    localparam int MAX_LAYERS = 16;
    localparam logic [7:0] ABORT_BYTE = 8'hFC;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_FWD,
        ARB_ABORT
    } arb_state_t;

    // Reference round-robin pick: first set bit of req at or after ptr, wrapping over n layers.
    function automatic logic [MAX_LAYERS-1:0] rr_pick(
        input logic [MAX_LAYERS-1:0] req,
        input logic [3:0]            ptr,
        input int unsigned           n
    );
        logic [MAX_LAYERS-1:0] g;
        logic                  found;
        int unsigned           idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_LAYERS; k++) begin
            idx = (32'(ptr) + k) % n;
            if (k < n && !found && req[idx[3:0]]) begin
                g[idx[3:0]] = 1'b1;
                found       = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/layers_rr_picker.sv
// Combinational round-robin picker: rotate request by ptr, isolate lowest bit, rotate back.
// Zero latency; no flow control of its own.
module layers_rr_picker #(
    parameter int LAYER_COUNT = 5,
    parameter int PTR_W       = (LAYER_COUNT > 1) ? $clog2(LAYER_COUNT) : 1
) (
    input  logic [LAYER_COUNT-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic [LAYER_COUNT-1:0] grant
);

    logic [LAYER_COUNT-1:0] rot;
    logic [LAYER_COUNT-1:0] lowest;

    // ptr is always < LAYER_COUNT, so the two shifts form a clean rotation.
    assign rot    = (req >> ptr) | (req << (LAYER_COUNT - ptr));
    assign lowest = rot & (~rot + 1'b1);
    assign grant  = (lowest << ptr) | (lowest >> (LAYER_COUNT - ptr));

endmodule

// File: rtl/layers_frame_arbiter.sv
// Frame-atomic round-robin arbiter of per-layer byte streams; 1 idle cycle per grant, then pass-through.
// Backpressure passes combinationally to the granted layer only. Watchdog under LAYERS_ARB_WATCHDOG_EN.
module layers_frame_arbiter
    import layers_arb_pkg::*;
#(
    parameter int LAYER_COUNT = 5,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                     clk_core,
    input  logic                     clk_core_rst,
    input  logic [LAYER_COUNT*8-1:0] s_axis_tdata,
    input  logic [LAYER_COUNT-1:0]   s_axis_tvalid,
    input  logic [LAYER_COUNT-1:0]   s_axis_tlast,
    output logic [LAYER_COUNT-1:0]   s_axis_tready,
    output logic [7:0]               m_axis_tdata,
    output logic [7:0]               m_axis_tdest,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    input  logic [LAYER_COUNT-1:0]   cfg_layer_enable,
    input  logic [TIMEOUT_W-1:0]     cfg_timeout_cycles,
    output logic [LAYER_COUNT-1:0]   status_grant,
    output logic                     status_busy,
    output logic                     stat_frame_done,
    output logic                     stat_frame_abort
);

    localparam int PTR_W = (LAYER_COUNT > 1) ? $clog2(LAYER_COUNT) : 1;

    arb_state_t             state_q, state_d;
    logic [LAYER_COUNT-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]       gidx_q, gidx_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [LAYER_COUNT-1:0] req;
    logic [LAYER_COUNT-1:0] pick;
    logic [PTR_W-1:0]       pick_idx;
    logic [PTR_W-1:0]       next_ptr;
    logic                   sel_vld;
    logic                   sel_last;
    logic [7:0]             sel_dat;
    logic                   wd_fire;

    assign req = s_axis_tvalid & cfg_layer_enable;

    layers_rr_picker #(
        .LAYER_COUNT (LAYER_COUNT),
        .PTR_W       (PTR_W)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < LAYER_COUNT; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_dat  = '0;
        for (int i = 0; i < LAYER_COUNT; i++) begin
            if (gidx_q == PTR_W'(i)) begin
                sel_vld  = s_axis_tvalid[i];
                sel_last = s_axis_tlast[i];
                sel_dat  = s_axis_tdata[i*8 +: 8];
            end
        end
    end

    assign next_ptr = (gidx_q == PTR_W'(LAYER_COUNT - 1)) ? '0 : gidx_q + 1'b1;

`ifdef LAYERS_ARB_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_cnt_q;

    // Counts starved cycles of the granted layer; saturates so it can never wrap past the limit.
    always_ff @(posedge clk_core) begin
        if (clk_core_rst) begin
            wd_cnt_q <= '0;
        end else if (state_q != ARB_FWD || (sel_vld && m_axis_tready)) begin
            wd_cnt_q <= '0;
        end else if (!sel_vld && wd_cnt_q != '1) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    // Only abort while the source is silent, so a presented beat is never withdrawn.
    assign wd_fire = (cfg_timeout_cycles != '0) && (wd_cnt_q == cfg_timeout_cycles) && !sel_vld;
`else
    logic unused_timeout;
    assign unused_timeout = ^cfg_timeout_cycles;
    assign wd_fire        = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        gidx_d           = gidx_q;
        rr_ptr_d         = rr_ptr_q;
        m_axis_tvalid    = 1'b0;
        m_axis_tdata     = '0;
        m_axis_tlast     = 1'b0;
        m_axis_tdest     = '0;
        s_axis_tready    = '0;
        stat_frame_done  = 1'b0;
        stat_frame_abort = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    state_d = ARB_FWD;
                end
            end
            ARB_FWD: begin
                m_axis_tvalid = sel_vld;
                m_axis_tdata  = sel_dat;
                m_axis_tlast  = sel_last;
                m_axis_tdest  = 8'(gidx_q) + 8'd1;
                s_axis_tready = grant_q & {LAYER_COUNT{m_axis_tready}};
                if (sel_vld && m_axis_tready && sel_last) begin
                    stat_frame_done = 1'b1;
                    rr_ptr_d        = next_ptr;
                    grant_d         = '0;
                    state_d         = ARB_IDLE;
                end else if (wd_fire) begin
                    state_d = ARB_ABORT;
                end
            end
`ifdef LAYERS_ARB_WATCHDOG_EN
            ARB_ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = ABORT_BYTE;
                m_axis_tlast  = 1'b1;
                m_axis_tdest  = 8'(gidx_q) + 8'd1;
                if (m_axis_tready) begin
                    stat_frame_abort = 1'b1;
                    rr_ptr_d         = next_ptr;
                    grant_d          = '0;
                    state_d          = ARB_IDLE;
                end
            end
`endif
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (clk_core_rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign status_grant = grant_q;
    assign status_busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_layers_frame_arbiter.sv
// Randomised bench for layers_frame_arbiter: queue-driven sources, beat monitor, frame-level round-robin model.
module tb_layers_frame_arbiter;

    localparam int LC = 5;
    localparam int TW = 16;

    logic            clk_core = 1'b0;
    logic            clk_core_rst = 1'b1;
    logic [LC*8-1:0] s_axis_tdata = '0;
    logic [LC-1:0]   s_axis_tvalid = '0;
    logic [LC-1:0]   s_axis_tlast = '0;
    logic [LC-1:0]   s_axis_tready;
    logic [7:0]      m_axis_tdata;
    logic [7:0]      m_axis_tdest;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic [LC-1:0]   cfg_layer_enable = '1;
    logic [TW-1:0]   cfg_timeout_cycles = '0;
    logic [LC-1:0]   status_grant;
    logic            status_busy;
    logic            stat_frame_done;
    logic            stat_frame_abort;

    always #5 clk_core = ~clk_core;

    layers_frame_arbiter #(.LAYER_COUNT(LC), .TIMEOUT_W(TW)) dut (
        .clk_core           (clk_core),
        .clk_core_rst       (clk_core_rst),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tready      (s_axis_tready),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tdest       (m_axis_tdest),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .cfg_layer_enable   (cfg_layer_enable),
        .cfg_timeout_cycles (cfg_timeout_cycles),
        .status_grant       (status_grant),
        .status_busy        (status_busy),
        .stat_frame_done    (stat_frame_done),
        .stat_frame_abort   (stat_frame_abort)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [8:0]  src_q [LC][$];   // {last, data} per layer, consumed by the source driver
    logic [8:0]  ref_q [LC][$];   // same frames, consumed by the model
    logic [16:0] exp_q [$];       // {dest, last, data}
    logic [16:0] obs_q [$];
    int          obs_cyc [$];
    int cyc = 0;
    int n_done = 0;
    int n_abort = 0;
    int stall_viol = 0;
    int pulse_viol = 0;
    int rdy_mode = 0;             // 0: always ready, 1: toggle, 2: random
    int model_ptr = 0;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_beat = '0;

    // Source driver and output monitor: drive on the falling edge, sample 1 ns later.
    initial begin
        forever begin
            @(negedge clk_core);
            case (rdy_mode)
                1:       m_axis_tready = ~m_axis_tready;
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b1;
            endcase
            for (int l = 0; l < LC; l++) begin
                if (src_q[l].size() > 0) begin
                    s_axis_tvalid[l]        = 1'b1;
                    s_axis_tlast[l]         = src_q[l][0][8];
                    s_axis_tdata[l*8 +: 8]  = src_q[l][0][7:0];
                end else begin
                    s_axis_tvalid[l]        = 1'b0;
                    s_axis_tlast[l]         = 1'b0;
                    s_axis_tdata[l*8 +: 8]  = 8'h00;
                end
            end
            #1;
            cyc++;
            if (prev_stall && !clk_core_rst &&
                !(m_axis_tvalid && {m_axis_tdest, m_axis_tlast, m_axis_tdata} == prev_beat))
                stall_viol++;
            prev_stall = m_axis_tvalid && !m_axis_tready && !clk_core_rst;
            prev_beat  = {m_axis_tdest, m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                obs_q.push_back({m_axis_tdest, m_axis_tlast, m_axis_tdata});
                obs_cyc.push_back(cyc);
            end
            if ((m_axis_tvalid && m_axis_tready && m_axis_tlast) ? (stat_frame_done == stat_frame_abort)
                                                                 : (stat_frame_done || stat_frame_abort))
                pulse_viol++;
            if (stat_frame_done) n_done++;
            if (stat_frame_abort) n_abort++;
            for (int l = 0; l < LC; l++) begin
                if (s_axis_tvalid[l] && s_axis_tready[l]) void'(src_q[l].pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_core);
        #2;
    endtask

    task automatic clear_queues();
        for (int l = 0; l < LC; l++) begin
            src_q[l].delete();
            ref_q[l].delete();
        end
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        model_ptr = 0;
    endtask

    task automatic do_reset();
        clk_core_rst = 1'b1;
        clear_queues();
        tick(2);
        clk_core_rst = 1'b0;
        tick(1);
    endtask

    task automatic push_frame(input int l, input int len, input bit with_last);
        logic [8:0] b;
        for (int i = 0; i < len; i++) begin
            b = {with_last && (i == len - 1), 8'($urandom)};
            src_q[l].push_back(b);
            ref_q[l].push_back(b);
        end
    endtask

    // Frame-level model: serve whole frames, always the first eligible layer at or after the pointer.
    task automatic build_expected(input logic [LC-1:0] en);
        int         pick;
        logic [8:0] b;
        forever begin
            pick = -1;
            for (int k = 0; k < LC; k++) begin
                if (pick < 0 && en[(model_ptr + k) % LC] && ref_q[(model_ptr + k) % LC].size() > 0)
                    pick = (model_ptr + k) % LC;
            end
            if (pick < 0) break;
            do begin
                b = ref_q[pick].pop_front();
                exp_q.push_back({8'(pick + 1), b});
            end while (!b[8] && ref_q[pick].size() > 0);
            model_ptr = (pick + 1) % LC;
        end
    endtask

    task automatic wait_beats(input int n, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() >= n) begin
                timed_out = 1'b0;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        tick(1);
        n_total++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0) $display("FAIL reset_handshake: tvalid=%b tready=%b, required 0/0", m_axis_tvalid, s_axis_tready);
        else n_pass++;
        n_total++;
        if (status_grant !== '0 || status_busy !== 1'b0) $display("FAIL reset_status: grant=%b busy=%b, required 0/0", status_grant, status_busy);
        else n_pass++;
        n_total++;
        if (stat_frame_done !== 1'b0 || stat_frame_abort !== 1'b0) $display("FAIL reset_pulses: done=%b abort=%b, required 0/0", stat_frame_done, stat_frame_abort);
        else n_pass++;
        clk_core_rst = 1'b0;
        tick(3);
        n_total++;
        if (status_busy !== 1'b0 || m_axis_tvalid !== 1'b0) $display("FAIL idle_no_req: busy=%b tvalid=%b, required 0/0", status_busy, m_axis_tvalid);
        else n_pass++;
    endtask

    task automatic test_two_layers();
        bit to;
        int t0, d0;
        do_reset();
        d0 = n_done;
        t0 = cyc;
        push_frame(0, 4, 1);
        push_frame(2, 4, 1);
        build_expected('1);
        wait_beats(8, 60, to);
        tick(2);
        n_total++;
        if (to || obs_q.size() != 8) $display("FAIL two_layers_count: got %0d beats, required 8", obs_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL two_layers_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        if (obs_q.size() == 8) begin
            n_total++;
            if (obs_cyc[0] != t0 + 2) $display("FAIL first_grant_latency: got %0d cycles, required 2", obs_cyc[0] - t0);
            else n_pass++;
            n_total++;
            if (obs_cyc[4] - obs_cyc[3] != 2) $display("FAIL frame_gap: got %0d cycles, required 2", obs_cyc[4] - obs_cyc[3]);
            else n_pass++;
        end
        n_total++;
        if (n_done - d0 != 2) $display("FAIL two_layers_done: got %0d pulses, required 2", n_done - d0);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        bit to;
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int l = 0; l < LC; l++) push_frame(l, 3, 1);
        build_expected('1);
        wait_beats(30, 120, to);
        n_total++;
        if (to) $display("FAIL rr_timeout: got %0d beats, required 30", obs_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i] || obs_q[i][16:9] != 8'((i / 3) % LC + 1))
                $display("FAIL rr_beat%0d: got %h, required %h (dest %0d)", i, obs_q[i], exp_q[i], (i / 3) % LC + 1);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int lasts, sv0;
        do_reset();
        sv0 = stall_viol;
        rdy_mode = 1;
        push_frame(0, 6, 1);
        build_expected('1);
        wait_beats(6, 60, to);
        tick(4);
        rdy_mode = 0;
        lasts = 0;
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i][8]) lasts++;
        n_total++;
        if (to || obs_q.size() != 6 || lasts != 1) $display("FAIL bp_frame: got %0d beats %0d tlast, required 6 beats 1 tlast", obs_q.size(), lasts);
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL bp_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (stall_viol != sv0) $display("FAIL bp_stable: got %0d unstable stalls, required 0", stall_viol - sv0);
        else n_pass++;
    endtask

    task automatic test_enable_mask();
        bit to;
        do_reset();
        push_frame(1, 6, 1);
        push_frame(1, 3, 1);
        push_frame(3, 4, 1);
        wait_beats(2, 20, to);
        cfg_layer_enable[1] = 1'b0;
        wait_beats(10, 60, to);
        tick(20);
        n_total++;
        if (to || obs_q.size() != 10 || src_q[1].size() != 3)
            $display("FAIL enable_count: got %0d beats %0d pending, required 10 beats 3 pending", obs_q.size(), src_q[1].size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < 10; i++) begin
            n_total++;
            if (obs_q[i][16:9] != ((i < 6) ? 8'd2 : 8'd4) || obs_q[i][8] != (i == 5 || i == 9))
                $display("FAIL enable_beat%0d: got dest %0d last %b, required dest %0d", i, obs_q[i][16:9], obs_q[i][8], (i < 6) ? 2 : 4);
            else n_pass++;
        end
        cfg_layer_enable = '1;
    endtask

    task automatic test_watchdog();
        bit to;
        int a0, d0, gap;
        do_reset();
        cfg_timeout_cycles = 16'd0;
        push_frame(0, 2, 0);
        wait_beats(2, 20, to);
        tick(30);
        n_total++;
        if (to || status_busy !== 1'b1 || obs_q.size() != 2) $display("FAIL wd_off_holds: busy=%b beats=%0d, required busy 1 beats 2", status_busy, obs_q.size());
        else n_pass++;
        do_reset();
        a0 = n_abort;
        d0 = n_done;
        cfg_timeout_cycles = 16'd10;
        push_frame(0, 2, 0);
`ifdef LAYERS_ARB_WATCHDOG_EN
        wait_beats(3, 60, to);
        tick(2);
        n_total++;
        if (to || obs_q[2] !== {8'd1, 1'b1, 8'hFC}) $display("FAIL wd_abort_beat: got %h, required 101fc", to ? 17'h0 : obs_q[2]);
        else n_pass++;
        if (!to) begin
            gap = obs_cyc[2] - obs_cyc[1] - 1;
            n_total++;
            if (gap < 10 || gap > 11) $display("FAIL wd_gap: got %0d idle cycles, required 10..11", gap);
            else n_pass++;
        end
        n_total++;
        if (n_abort - a0 != 1 || n_done != d0 || status_busy !== 1'b0)
            $display("FAIL wd_pulses: abort=%0d done=%0d busy=%b, required 1/0/0", n_abort - a0, n_done - d0, status_busy);
        else n_pass++;
        push_frame(0, 2, 1);
        wait_beats(5, 30, to);
        n_total++;
        if (to || obs_q[3][16:9] != 8'd1 || obs_q[4][8] != 1'b1) $display("FAIL wd_regrant: got %0d beats, required 5 with layer 1 frame", obs_q.size());
        else n_pass++;
`else
        wait_beats(2, 20, to);
        tick(40);
        n_total++;
        if (to || status_busy !== 1'b1 || obs_q.size() != 2 || n_abort != a0)
            $display("FAIL wd_absent: busy=%b beats=%0d aborts=%0d, required 1/2/0", status_busy, obs_q.size(), n_abort - a0);
        else n_pass++;
`endif
        cfg_timeout_cycles = 16'd0;
        do_reset();
    endtask

    task automatic test_reset_midframe();
        bit to;
        do_reset();
        push_frame(3, 2, 1);
        wait_beats(2, 20, to);
        push_frame(2, 8, 1);
        wait_beats(5, 30, to);
        clk_core_rst = 1'b1;
        tick(1);
        n_total++;
        if (to || m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || status_grant !== '0)
            $display("FAIL midframe_reset: tvalid=%b tready=%b grant=%b, required 0/0/0", m_axis_tvalid, s_axis_tready, status_grant);
        else n_pass++;
        clear_queues();
        tick(1);
        clk_core_rst = 1'b0;
        tick(1);
        push_frame(3, 3, 1);
        push_frame(4, 3, 1);
        build_expected('1);
        wait_beats(6, 40, to);
        n_total++;
        if (to) $display("FAIL post_reset_timeout: got %0d beats, required 6", obs_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL post_reset_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit to;
        logic [LC-1:0] en;
        int sv0;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            sv0 = stall_viol;
            en = LC'($urandom_range(1, (1 << LC) - 1));
            cfg_layer_enable = en;
            rdy_mode = 2;
            for (int l = 0; l < LC; l++)
                for (int f = $urandom_range(0, 2); f > 0; f--) push_frame(l, $urandom_range(1, 6), 1);
            push_frame($urandom_range(0, LC - 1), $urandom_range(1, 6), 1);
            build_expected(en);
            wait_beats(exp_q.size(), 400, to);
            tick(6);
            n_total++;
            if (to || obs_q.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d beats, required %0d", it, obs_q.size(), exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_total++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL rand%0d_beat%0d: got %h, required %h", it, i, obs_q[i], exp_q[i]);
                else n_pass++;
            end
            n_total++;
            if (stall_viol != sv0) $display("FAIL rand%0d_stable: got %0d unstable stalls, required 0", it, stall_viol - sv0);
            else n_pass++;
        end
        rdy_mode = 0;
        cfg_layer_enable = '1;
    endtask

    initial begin
        tick(1);
        test_reset();
        test_two_layers();
        test_round_robin();
        test_backpressure();
        test_enable_mask();
        test_watchdog();
        test_reset_midframe();
        test_random();
        n_total++;
        if (pulse_viol != 0) $display("FAIL stat_pulses: got %0d mismatched pulse cycles, required 0", pulse_viol);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
